// File: rtl/refresh_arbiter_pkg.sv
// Shared types and defaults for the DRAM refresh arbiter.
package refresh_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU     = 3'd1,
    REF_CAS = 3'd2,
    REF_RAS = 3'd3,
    REF_PRE = 3'd4
  } arb_state_e;

  localparam int PEND_W        = 2;
  localparam int PHASE_W       = 4;
  localparam int DEF_CAS_SETUP = 1;
  localparam int DEF_RAS_PULSE = 4;
  localparam int DEF_PRECHARGE = 3;
  localparam int DEF_PEND_MAX  = 3;

  function automatic logic is_ref(arb_state_e s);
    return (s == REF_CAS) || (s == REF_RAS) || (s == REF_PRE);
  endfunction

endpackage

// File: rtl/refresh_pend_ctr.sv
// Counts owed refreshes: RefReq rising-edge detect, saturating up/down count, sticky miss.
module refresh_pend_ctr
  import refresh_arbiter_pkg::*;
#(
  parameter int PEND_MAX = DEF_PEND_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_req,
  input  logic              dec,
  output logic [PEND_W-1:0] pend,
  output logic              ref_miss
);

  localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(PEND_MAX);

  logic              req_q, req_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              miss_q, miss_d;
  logic              inc;

  always_comb begin
    req_d  = ref_req;
    inc    = ref_req & ~req_q;
    pend_d = pend_q;
    miss_d = miss_q;
    // A simultaneous request and completion cancel; nothing is lost then.
    if (inc && !dec) begin
      if (pend_q == MAX_CNT) miss_d = 1'b1;
      else                   pend_d = pend_q + 1'b1;
    end else if (dec && !inc && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= 1'b0;
      pend_q <= '0;
      miss_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      pend_q <= pend_d;
      miss_q <= miss_d;
    end
  end

  assign pend     = pend_q;
  assign ref_miss = miss_q;

endmodule

// File: rtl/refresh_arbiter.sv
// Arbitrates the DRAM array between CPU accesses and CAS-before-RAS refresh.
// Optional REFARB_STATS_EN adds UrgCnt, a saturating count of urgent refresh starts.
module refresh_arbiter
  import refresh_arbiter_pkg::*;
#(
  parameter int CAS_SETUP = DEF_CAS_SETUP,
  parameter int RAS_PULSE = DEF_RAS_PULSE,
  parameter int PRECHARGE = DEF_PRECHARGE,
  parameter int PEND_MAX  = DEF_PEND_MAX
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RefReq,
  input  logic              RefUrg,
  input  logic              BusReq,
  input  logic              BusDone,
  output logic              CPUGnt,
  output logic              nRAS,
  output logic              nCAS,
  output logic              RefAck,
  output logic              RefBusy,
  output logic              RefMiss,
`ifdef REFARB_STATS_EN
  output logic [7:0]        UrgCnt,
`endif
  output logic [PEND_W-1:0] Pend
);

  localparam logic [PHASE_W-1:0] CAS_LD = PHASE_W'(CAS_SETUP - 1);
  localparam logic [PHASE_W-1:0] RAS_LD = PHASE_W'(RAS_PULSE - 1);
  localparam logic [PHASE_W-1:0] PRE_LD = PHASE_W'(PRECHARGE - 1);

  arb_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               gnt_q, gnt_d;
  logic               nras_q, nras_d;
  logic               ncas_q, ncas_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               ref_done;
  logic               urg_go;
  logic [PEND_W-1:0]  pend;

  refresh_pend_ctr #(.PEND_MAX(PEND_MAX)) u_pend (
    .clk      (CLK),
    .rst      (RST),
    .ref_req  (RefReq),
    .dec      (ref_done),
    .pend     (pend),
    .ref_miss (RefMiss)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = (phase_q != '0) ? phase_q - 1'b1 : '0;
    urg_go   = 1'b0;
    ref_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (RefUrg && pend != '0) begin
          state_d = REF_CAS;
          urg_go  = 1'b1;
        end else if (BusReq) begin
          state_d = CPU;
        end else if (pend != '0) begin
          state_d = REF_CAS;
        end
      end
      CPU:     if (BusDone) state_d = IDLE;
      REF_CAS: if (phase_q == '0) state_d = REF_RAS;
      REF_RAS: if (phase_q == '0) state_d = REF_PRE;
      REF_PRE: begin
        if (phase_q == '0) begin
          state_d  = IDLE;
          ref_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Phase timer counts down to zero and is reloaded on every state entry.
    if (state_d != state_q) begin
      case (state_d)
        REF_CAS: phase_d = CAS_LD;
        REF_RAS: phase_d = RAS_LD;
        REF_PRE: phase_d = PRE_LD;
        default: phase_d = '0;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    gnt_d  = (state_d == CPU);
    ncas_d = !((state_d == REF_CAS) || (state_d == REF_RAS));
    nras_d = (state_d != REF_RAS);
    ack_d  = ref_done;
    busy_d = is_ref(state_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      gnt_q   <= 1'b0;
      nras_q  <= 1'b1;
      ncas_q  <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gnt_q   <= gnt_d;
      nras_q  <= nras_d;
      ncas_q  <= ncas_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign CPUGnt  = gnt_q;
  assign nRAS    = nras_q;
  assign nCAS    = ncas_q;
  assign RefAck  = ack_q;
  assign RefBusy = busy_q;
  assign Pend    = pend;

`ifdef REFARB_STATS_EN
  logic [7:0] urg_cnt_q, urg_cnt_d;

  always_comb begin
    urg_cnt_d = urg_cnt_q;
    if (urg_go && urg_cnt_q != 8'hFF) urg_cnt_d = urg_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) urg_cnt_q <= '0;
    else     urg_cnt_q <= urg_cnt_d;
  end

  assign UrgCnt = urg_cnt_q;
`else
  logic unused_urg;
  assign unused_urg = urg_go;
`endif

endmodule

// File: tb/tb_refresh_arbiter.sv
// Directed bench for refresh_arbiter with default timing (1/4/3, PEND_MAX=3).
module tb_refresh_arbiter;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RefReq = 1'b0, RefUrg = 1'b0, BusReq = 1'b0, BusDone = 1'b0;
  logic       CPUGnt, nRAS, nCAS, RefAck, RefBusy, RefMiss;
  logic [1:0] Pend;
`ifdef REFARB_STATS_EN
  logic [7:0] UrgCnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  refresh_arbiter dut (
    .CLK     (CLK),
    .RST     (RST),
    .RefReq  (RefReq),
    .RefUrg  (RefUrg),
    .BusReq  (BusReq),
    .BusDone (BusDone),
    .CPUGnt  (CPUGnt),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .RefAck  (RefAck),
    .RefBusy (RefBusy),
    .RefMiss (RefMiss),
`ifdef REFARB_STATS_EN
    .UrgCnt  (UrgCnt),
`endif
    .Pend    (Pend)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Returns on the cycle RefAck is seen, or flags a timeout.
  task automatic wait_ack(input string tag);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (RefAck) begin
        seen = 1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int acks;
    int low;

    // Reset state
    tick(); tick();
    chk("rst_gnt", CPUGnt, 0);
    chk("rst_nras", nRAS, 1);
    chk("rst_ncas", nCAS, 1);
    chk("rst_ack", RefAck, 0);
    chk("rst_busy", RefBusy, 0);
    chk("rst_miss", RefMiss, 0);
    chk("rst_pend", Pend, 0);
`ifdef REFARB_STATS_EN
    chk("rst_urgcnt", UrgCnt, 0);
`endif
    RST = 1'b0;
    tick();

    // 1: single idle refresh, full strobe sequence
    RefReq = 1'b1;
    tick();
    chk("t1_pend1", Pend, 1);
    chk("t1_ncas_idle", nCAS, 1);
    RefReq = 1'b0;
    tick();
    chk("t1_cas_ncas", nCAS, 0);
    chk("t1_cas_nras", nRAS, 1);
    chk("t1_cas_busy", RefBusy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_ras_nras", nRAS, 0);
      chk("t1_ras_ncas", nCAS, 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_pre_nras", nRAS, 1);
      chk("t1_pre_ncas", nCAS, 1);
      chk("t1_pre_busy", RefBusy, 1);
      chk("t1_pre_ack", RefAck, 0);
    end
    tick();
    chk("t1_ack", RefAck, 1);
    chk("t1_pend0", Pend, 0);
    chk("t1_busy_off", RefBusy, 0);
    tick();
    chk("t1_ack_pulse", RefAck, 0);

    // 2: BusReq beats a non-urgent pending refresh
    RefReq = 1'b1; BusReq = 1'b1;
    tick();
    chk("t2_gnt", CPUGnt, 1);
    chk("t2_pend", Pend, 1);
    RefReq = 1'b0;
    tick(); tick();
    chk("t2_gnt_hold", CPUGnt, 1);
    chk("t2_ncas_hold", nCAS, 1);
    BusDone = 1'b1; BusReq = 1'b0;
    tick();
    BusDone = 1'b0;
    chk("t2_gnt_drop", CPUGnt, 0);
    tick();
    chk("t2_ref_start", nCAS, 0);
    chk("t2_ref_busy", RefBusy, 1);
    wait_ack("t2_ack");
    chk("t2_pend0", Pend, 0);

    // 3: urgent refresh goes ahead of a waiting CPU request
    RefReq = 1'b1; RefUrg = 1'b1;
    tick();
    chk("t3_pend", Pend, 1);
    chk("t3_idle_ncas", nCAS, 1);
    BusReq = 1'b1; RefReq = 1'b0;
    tick();
    chk("t3_ref_first", nCAS, 0);
    chk("t3_gnt0", CPUGnt, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_gnt_held0", CPUGnt, 0);
      chk("t3_busy", RefBusy, 1);
    end
    tick();
    chk("t3_ack", RefAck, 1);
    chk("t3_gnt_idle", CPUGnt, 0);
    tick();
    chk("t3_gnt_after", CPUGnt, 1);
`ifdef REFARB_STATS_EN
    chk("t3_urgcnt", UrgCnt, 1);
`endif

    // 4: urgent request during a CPU grant does not preempt
    RefReq = 1'b1;
    tick();
    chk("t4_pend", Pend, 1);
    RefReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_preempt", CPUGnt, 1);
      chk("t4_ncas_hi", nCAS, 1);
    end
    BusDone = 1'b1;
    tick();
    BusDone = 1'b0;
    chk("t4_gnt_drop", CPUGnt, 0);
    tick();
    chk("t4_ref_start", nCAS, 0);
    chk("t4_gnt0", CPUGnt, 0);
    wait_ack("t4_ack");
    tick();
    chk("t4_gnt_after", CPUGnt, 1);
`ifdef REFARB_STATS_EN
    chk("t4_urgcnt", UrgCnt, 2);
`endif
    RefUrg = 1'b0;

    // 5: saturation while the CPU holds the array
    chk("t5_miss0", RefMiss, 0);
    for (int k = 0; k < 4; k++) begin
      RefReq = 1'b1;
      tick();
      RefReq = 1'b0;
      tick();
    end
    chk("t5_pend_sat", Pend, 3);
    chk("t5_miss", RefMiss, 1);
    chk("t5_gnt", CPUGnt, 1);
    BusReq = 1'b0; BusDone = 1'b1;
    tick();
    BusDone = 1'b0;
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (RefAck) acks++;
    end
    chk("t5_acks", acks, 3);
    chk("t5_pend0", Pend, 0);
    chk("t5_miss_sticky", RefMiss, 1);

    // 6: reset in the middle of REF_RAS
    RefReq = 1'b1;
    tick();
    RefReq = 1'b0;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!nRAS) begin
        low = 1;
        break;
      end
    end
    chk("t6_in_ras", low, 1);
    chk("t6_pend_before", Pend, 1);
    #2 RST = 1'b1;
    #1;
    chk("t6_nras", nRAS, 1);
    chk("t6_ncas", nCAS, 1);
    chk("t6_pend", Pend, 0);
    chk("t6_busy", RefBusy, 0);
    chk("t6_miss_clr", RefMiss, 0);
`ifdef REFARB_STATS_EN
    chk("t6_urgcnt", UrgCnt, 0);
`endif
    tick();
    RST = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
